// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply/accumulate controller:
// operation codes, default latency and small op-decode helpers.
package mul_pkg;

    localparam int MUL_LAT_DEFAULT = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5
    } mul_op_e;

    // How the product is combined with the accumulator.
    localparam logic [1:0] MODE_PLAIN = 2'd0;
    localparam logic [1:0] MODE_ADD   = 2'd1;
    localparam logic [1:0] MODE_SUB   = 2'd2;

    // Signed ops; the reserved codes fall through to unsigned (MULTU behaviour).
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Accumulation mode; the reserved codes give a plain product.
    function automatic logic [1:0] op_mode(input logic [2:0] op);
        logic [1:0] m;
        m = MODE_PLAIN;
        if (op == OP_MADD || op == OP_MADDU) m = MODE_ADD;
        if (op == OP_MSUB || op == OP_MSUBU) m = MODE_SUB;
        return m;
    endfunction

endpackage

// File: rtl/mul_core_pipe.sv
// Unsigned WIDTH x WIDTH multiplier followed by a plain register pipeline.
// The product is formed into the first register; the remaining STAGES-1
// registers only delay it. No reset: validity is tracked by the controller.
module mul_core_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p
);

    logic [2*WIDTH-1:0] pipe [STAGES];

    // Multiply into stage 0, then shift the product down the pipeline.
    always_ff @(posedge clk) begin
        pipe[0] <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        for (int i = 1; i < STAGES; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign p = pipe[STAGES-1];

endmodule

// File: rtl/mul_iter_ctrl.sv
// Multi-cycle multiply / multiply-accumulate controller.
// Handshake: a start is accepted when mul_begin=1, mul_flush=0 and the block
// is IDLE or DONE; mul_begin in BUSY is dropped. mul_done pulses for one
// cycle exactly LATENCY cycles after the accepting edge, and mul_res holds
// until the next completion. mul_flush aborts anything in flight.
module mul_iter_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = MUL_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mul_begin,
    input  logic [2:0]           mul_op,
    input  logic [WIDTH-1:0]     mul_a,
    input  logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic                 mul_flush,
    output logic                 mul_busy,
    output logic                 mul_done,
    output logic [2*WIDTH-1:0]   mul_res,
    output logic [1:0]           dbg_state
);

    localparam int STAGES = LATENCY - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic               start_ok;

    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic               neg_q;
    logic [1:0]         mode_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] res_next;

    assign start_ok = mul_begin && !mul_flush && (state == S_IDLE || state == S_DONE);

    // Signed ops work on magnitudes; negating the most negative value wraps
    // back to itself, which is the correct unsigned magnitude.
    assign sgn   = op_is_signed(mul_op);
    assign a_neg = sgn & mul_a[WIDTH-1];
    assign b_neg = sgn & mul_b[WIDTH-1];
    assign a_mag = a_neg ? -mul_a : mul_a;
    assign b_mag = b_neg ? -mul_b : mul_b;

    // Capture operands and accumulator on an accepted start.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            mag_a_q <= a_mag;
            mag_b_q <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            mode_q  <= op_mode(mul_op);
            acc_q   <= acc_in;
        end
    end

    mul_core_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_core (
        .clk (clk),
        .a   (mag_a_q),
        .b   (mag_b_q),
        .p   (prod)
    );

    // Sign fix-up and accumulation on the pipeline output (modulo 2^(2*WIDTH)).
    always_comb begin
        prod_s = neg_q ? -prod : prod;
        case (mode_q)
            MODE_ADD: res_next = acc_q + prod_s;
            MODE_SUB: res_next = acc_q - prod_s;
            default:  res_next = prod_s;
        endcase
    end

    // Control FSM: reset beats flush, flush beats start and completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            mul_done <= 1'b0;
            mul_res  <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_flush) begin
                state <= S_IDLE;
                cnt   <= 4'd0;
            end else if (start_ok) begin
                state <= S_BUSY;
                cnt   <= 4'(LATENCY - 1);
            end else begin
                case (state)
                    S_BUSY: begin
                        if (cnt == 4'd0) begin
                            state    <= S_DONE;
                            mul_done <= 1'b1;
                            mul_res  <= res_next;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign mul_busy  = (state == S_BUSY);
    assign dbg_state = state;

endmodule

// File: doc/mul_iter_ctrl.md
MUL_ITER_CTRL -- requirements
Module: mul_iter_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand width in bits; legal values are 8..64.
REQ-002 Parameter LATENCY, default 5, sets the cycles from accepted start to done; legal values are 2..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 Port mul_begin, input, 1 bit: start request, sampled every cycle.
REQ-006 Port mul_op, input, 3 bits: operation code, sampled only with an accepted start.
- MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5.
- Codes 6..7 are reserved.
REQ-007 Port mul_a and mul_b, input, WIDTH bits each: operands, sampled with an accepted start.
REQ-008 Port acc_in, input, 2*WIDTH bits: {HI,LO} accumulator, sampled with an accepted start.
REQ-009 Port mul_flush, input, 1 bit: abort of any in-flight operation.
REQ-010 Port mul_busy, output, 1 bit: an operation is in flight.
REQ-011 Port mul_done, output, 1 bit: single-cycle result-valid pulse.
REQ-012 Port mul_res, output, 2*WIDTH bits: result, held stable from done until the next accepted start.

Function
REQ-013 State machine states are IDLE, BUSY and DONE.
REQ-014 An accepted start is mul_begin=1 in state IDLE or DONE with mul_flush=0.
- It latches the operation code, operands and accumulator.
- It loads the cycle counter with LATENCY-1 and enters BUSY.
REQ-015 In BUSY the counter decrements once per cycle; at counter 0 the block registers the result and enters DONE.
- mul_done therefore rises exactly LATENCY cycles after the accepted-start edge.
REQ-016 DONE lasts one cycle, then goes to IDLE, unless an accepted start in DONE sends it directly to BUSY (back-to-back operation).
REQ-017 mul_begin while in BUSY is ignored; nothing is queued.
REQ-018 Signed operations (MULT, MADD, MSUB) multiply the operand magnitudes unsigned.
- The product is negated only when the operand signs differ.
- A WIDTH-bit minimum value is handled correctly: with WIDTH=32, 0x80000000*0x80000000 = 0x4000000000000000.
REQ-019 Unsigned operations zero-extend both operands.
REQ-020 MADD/MADDU give acc_in + product; MSUB/MSUBU give acc_in - product; both modulo 2^(2*WIDTH), with no overflow flag.
REQ-021 A reserved operation code behaves as MULTU.
REQ-022 mul_flush=1 in any state forces IDLE at the next edge.
- mul_done stays 0 and mul_res keeps its previous value.
- Flush has priority over a simultaneous start and over a completion in the same cycle.
REQ-023 mul_busy=1 exactly while the state is BUSY.
REQ-024 mul_res changes only on the completion edge.

Reset
REQ-025 rst=0 at a clock edge sets state IDLE, counter 0, mul_busy=0, mul_done=0 and mul_res all zeros, regardless of any operation in flight.
REQ-026 Reset has priority over flush and start; an operation interrupted by reset produces no mul_done.

Structure
REQ-027 The operation-code enum and the MUL_LAT_DEFAULT constant live in the shared package mul_pkg.
REQ-028 The unsigned magnitude product is computed in one sub-module, mul_core_pipe.
- Parameters WIDTH and STAGES=LATENCY-1.
- Registered pipeline, no reset on its datapath.
- The controller does sign fix-up and accumulation after its output.

Verification
REQ-029 Default parameters; MULTU with a=0xFFFFFFFF, b=2 -> mul_done exactly 5 cycles after the start edge, mul_res=0x00000001FFFFFFFE.
REQ-030 MULT with a=-3, b=7 -> mul_res=0xFFFFFFFFFFFFFFEB; MULT with a=0x80000000, b=0x80000000 -> mul_res=0x4000000000000000.
REQ-031 MSUB with acc_in=0, a=1, b=1 -> mul_res=all ones; MADDU with acc_in=0xFFFFFFFFFFFFFFFF, a=1, b=1 -> mul_res=0 (wrap).
REQ-032 Start in cycle 0; mul_begin held high through BUSY; second start in the DONE cycle -> exactly two mul_done pulses, 5 cycles apart, each with its own result.
REQ-033 mul_flush 2 cycles after start -> no mul_done, mul_busy=0 the next cycle, mul_res unchanged; then flush and start asserted together -> start ignored.
REQ-034 rst=0 during BUSY -> all outputs zero next cycle, no mul_done; then WIDTH=16, LATENCY=3 instance, MULT a=0xFFFF, b=0xFFFF -> mul_res=0x00000001 after 3 cycles.
